// File: rtl/sprite_hshrink_seq.sv
// Sequencer for one horizontal-shrink keep-mask generator: takes 16-pixel tiles,
// steps the generator two pixels at a time and turns keep bits into line-buffer writes.
module sprite_hshrink_seq #(
  parameter int XW = 9
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          CK_EN,
  input  logic          FLUSH,
  input  logic          TILE_VALID,
  output logic          TILE_READY,
  input  logic [3:0]    TILE_SHRINK,
  input  logic [XW-1:0] TILE_X,
  input  logic          TILE_FLIP,
  output logic [3:0]    HS_SHRINK,
  output logic          HS_L,
  output logic          HS_CK_EN,
  input  logic          HS_OUTA,
  input  logic          HS_OUTB,
  output logic          LB_WE_A,
  output logic          LB_WE_B,
  output logic [XW-1:0] LB_ADDR_A,
  output logic [XW-1:0] LB_ADDR_B,
  output logic [3:0]    LB_PIX_A,
  output logic [3:0]    LB_PIX_B,
  output logic          TILE_DONE,
  output logic [4:0]    KEPT,
  output logic          DBG_STATE,
  output logic [2:0]    DBG_K
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [XW-1:0] x_q, x_d;
  logic          flip_q, flip_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          we_a_q, we_a_d;
  logic          we_b_q, we_b_d;
  logic [XW-1:0] addr_a_q, addr_a_d;
  logic [XW-1:0] addr_b_q, addr_b_d;
  logic [3:0]    pix_a_q, pix_a_d;
  logic [3:0]    pix_b_q, pix_b_d;
  logic          done_q, done_d;
  logic [4:0]    kept_q, kept_d;

  logic          tile_ready;
  logic          accept;
  logic          last_step;

  // Handshake: a tile transfers on a CLK edge where CK_EN, TILE_VALID and TILE_READY
  // are all high. READY is offered in IDLE and on the final step of a tile (so tiles
  // chain without a bubble), is never offered during FLUSH, and VALID may drop freely.
  assign last_step  = (state_q == EMIT) && (k_q == 3'd7);
  assign tile_ready = ((state_q == IDLE) || last_step) && !FLUSH;
  assign accept     = CK_EN && TILE_VALID && tile_ready;

  assign TILE_READY = tile_ready;
  assign HS_SHRINK  = TILE_SHRINK;
  assign HS_L       = ~(TILE_VALID & tile_ready);
  assign HS_CK_EN   = CK_EN;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    x_d      = x_q;
    flip_d   = flip_q;
    cnt_d    = cnt_q;
    we_a_d   = we_a_q;
    we_b_d   = we_b_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    pix_a_d  = pix_a_q;
    pix_b_d  = pix_b_q;
    done_d   = 1'b0;
    kept_d   = kept_q;

    if (FLUSH) begin
      state_d = IDLE;
      k_d     = 3'd0;
      we_a_d  = 1'b0;
      we_b_d  = 1'b0;
    end else if (CK_EN) begin
      we_a_d = 1'b0;
      we_b_d = 1'b0;

      if (state_q == EMIT) begin
        we_a_d   = HS_OUTA;
        we_b_d   = HS_OUTB;
        addr_a_d = x_q;
        addr_b_d = x_q + XW'(HS_OUTA);
        x_d      = x_q + XW'(HS_OUTA) + XW'(HS_OUTB);
        // Flipped tiles read the source row right to left: 15-2k = ~2k in 4 bits.
        pix_a_d  = flip_q ? {~k_q, 1'b1} : {k_q, 1'b0};
        pix_b_d  = flip_q ? {~k_q, 1'b0} : {k_q, 1'b1};
        cnt_d    = cnt_q + 5'(HS_OUTA) + 5'(HS_OUTB);
        k_d      = k_q + 3'd1;
        if (k_q == 3'd7) begin
          done_d  = 1'b1;
          kept_d  = cnt_q + 5'(HS_OUTA) + 5'(HS_OUTB);
          state_d = IDLE;
          k_d     = 3'd0;
        end
      end

      // A chained accept overrides the counters after the old tile's last pixels are issued.
      if (accept) begin
        x_d     = TILE_X;
        flip_d  = TILE_FLIP;
        cnt_d   = 5'd0;
        state_d = EMIT;
        k_d     = 3'd0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      k_q      <= 3'd0;
      x_q      <= '0;
      flip_q   <= 1'b0;
      cnt_q    <= 5'd0;
      we_a_q   <= 1'b0;
      we_b_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      pix_a_q  <= 4'd0;
      pix_b_q  <= 4'd0;
      done_q   <= 1'b0;
      kept_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      x_q      <= x_d;
      flip_q   <= flip_d;
      cnt_q    <= cnt_d;
      we_a_q   <= we_a_d;
      we_b_q   <= we_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      pix_a_q  <= pix_a_d;
      pix_b_q  <= pix_b_d;
      done_q   <= done_d;
      kept_q   <= kept_d;
    end
  end

  assign LB_WE_A   = we_a_q;
  assign LB_WE_B   = we_b_q;
  assign LB_ADDR_A = addr_a_q;
  assign LB_ADDR_B = addr_b_q;
  assign LB_PIX_A  = pix_a_q;
  assign LB_PIX_B  = pix_b_q;
  assign TILE_DONE = done_q;
  assign KEPT      = kept_q;
  assign DBG_STATE = state_q;
  assign DBG_K     = k_q;

endmodule

// File: tb/tb_sprite_hshrink_seq.sv
// Directed bench for sprite_hshrink_seq with a behavioural keep-mask generator attached
// to the HS_* port; pixel i of a tile is bit i of the mask.
module tb_sprite_hshrink_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ck_en = 1'b1;
  logic       flush = 1'b0;
  logic       tile_valid = 1'b0;
  logic [3:0] tile_shrink = 4'h0;
  logic [8:0] tile_x = 9'h000;
  logic       tile_flip = 1'b0;

  logic       tile_ready, hs_l, hs_ck_en, hs_outa, hs_outb;
  logic [3:0] hs_shrink;
  logic       lb_we_a, lb_we_b, tile_done, dbg_state;
  logic [8:0] lb_addr_a, lb_addr_b;
  logic [3:0] lb_pix_a, lb_pix_b;
  logic [4:0] kept;
  logic [2:0] dbg_k;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_kept = 5'd0;

  always #5 clk = ~clk;

  sprite_hshrink_seq #(.XW(9)) dut (
    .CLK(clk), .nRESET(rst_n), .CK_EN(ck_en), .FLUSH(flush),
    .TILE_VALID(tile_valid), .TILE_READY(tile_ready), .TILE_SHRINK(tile_shrink),
    .TILE_X(tile_x), .TILE_FLIP(tile_flip),
    .HS_SHRINK(hs_shrink), .HS_L(hs_l), .HS_CK_EN(hs_ck_en),
    .HS_OUTA(hs_outa), .HS_OUTB(hs_outb),
    .LB_WE_A(lb_we_a), .LB_WE_B(lb_we_b), .LB_ADDR_A(lb_addr_a), .LB_ADDR_B(lb_addr_b),
    .LB_PIX_A(lb_pix_a), .LB_PIX_B(lb_pix_b), .TILE_DONE(tile_done), .KEPT(kept),
    .DBG_STATE(dbg_state), .DBG_K(dbg_k)
  );

  // Keep patterns for the shrink values exercised here.
  function automatic logic [15:0] keep_mask(input logic [3:0] s);
    case (s)
      4'h0:    keep_mask = 16'h0100;
      4'h7:    keep_mask = 16'h5555;
      4'hF:    keep_mask = 16'hFFFF;
      default: keep_mask = 16'h0000;
    endcase
  endfunction

  logic [15:0] gen_q = 16'h0000;
  always @(posedge clk)
    if (hs_ck_en) gen_q <= hs_l ? {2'b00, gen_q[15:2]} : keep_mask(hs_shrink);
  assign hs_outa = gen_q[0];
  assign hs_outb = gen_q[1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [33:0] all_out;
    #2;
    all_out = {lb_we_a, lb_we_b, lb_addr_a, lb_addr_b, lb_pix_a, lb_pix_b, tile_done, kept};
    checks++;
    if (all_out !== 34'h0 || dbg_state !== 1'b0 || dbg_k !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h state=%b k=%0d expected 0", all_out, dbg_state, dbg_k);
    end
    checks++;
    if (tile_ready !== 1'b1 || hs_l !== 1'b1 || hs_ck_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb ready=%b hs_l=%b hs_ck_en=%b expected 1 1 1", tile_ready, hs_l, hs_ck_en);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tile(input logic [3:0] shrink, input logic [8:0] x0, input logic flip);
    logic [15:0] m;
    logic [8:0]  x;
    logic        ea, eb;
    logic [3:0]  pa, pb;
    logic [4:0]  n;
    logic [27:0] exp_v, got_v;
    m = keep_mask(shrink);
    x = x0;
    n = 5'd0;
    ck_en = 1'b1;
    flush = 1'b0;
    tile_valid = 1'b1; tile_shrink = shrink; tile_x = x0; tile_flip = flip;
    #1;
    checks++;
    if (tile_ready !== 1'b1 || hs_l !== 1'b0 || hs_shrink !== shrink) begin
      errors++;
      $display("FAIL accept_%h_%h ready=%b hs_l=%b hs_shrink=%h expected 1 0 %h",
               shrink, x0, tile_ready, hs_l, hs_shrink, shrink);
    end
    tick();
    tile_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      ea = m[2*k];
      eb = m[2*k+1];
      pa = flip ? 4'(15 - 2*k) : 4'(2*k);
      pb = flip ? 4'(14 - 2*k) : 4'(2*k + 1);
      exp_v = {ea, eb, x, x + 9'(ea), pa, pb};
      got_v = {lb_we_a, lb_we_b, lb_addr_a, lb_addr_b, lb_pix_a, lb_pix_b};
      x = x + 9'(ea) + 9'(eb);
      n = n + 5'(ea) + 5'(eb);
      checks++;
      if (got_v !== exp_v || tile_done !== ((k == 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL tile_%h_%h_f%b step %0d got %h done=%b expected %h done=%b",
                 shrink, x0, flip, k, got_v, tile_done, exp_v, (k == 7));
      end
    end
    exp_kept = n;
    checks++;
    if (kept !== n) begin
      errors++;
      $display("FAIL kept_%h_%h got %0d expected %0d", shrink, x0, kept, n);
    end
    tick();
    checks++;
    if ({lb_we_a, lb_we_b, tile_done} !== 3'b000 || kept !== n || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_%h_%h we=%b%b done=%b kept=%0d state=%b expected 00 0 %0d 0",
               shrink, x0, lb_we_a, lb_we_b, tile_done, kept, dbg_state, n);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  a;
    logic [3:0]  p;
    logic [27:0] exp_v, got_v;
    ck_en = 1'b1;
    tile_valid = 1'b1; tile_shrink = 4'hF; tile_x = 9'd0; tile_flip = 1'b0;
    tick();
    tile_valid = 1'b0;
    for (int s = 0; s < 16; s++) begin
      if (s == 7) begin
        tile_valid = 1'b1; tile_x = 9'd16;
        #1;
        checks++;
        if (tile_ready !== 1'b1 || hs_l !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready got ready=%b hs_l=%b expected 1 0", tile_ready, hs_l);
        end
      end
      tick();
      tile_valid = 1'b0;
      a = 9'(2*s);
      p = 4'(2*(s % 8));
      exp_v = {1'b1, 1'b1, a, a + 9'd1, p, p + 4'd1};
      got_v = {lb_we_a, lb_we_b, lb_addr_a, lb_addr_b, lb_pix_a, lb_pix_b};
      checks++;
      if (got_v !== exp_v || tile_done !== ((s % 8 == 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL b2b step %0d got %h done=%b expected %h done=%b",
                 s, got_v, tile_done, exp_v, (s % 8 == 7));
      end
      if (s == 7) begin
        checks++;
        if (kept !== 5'd16 || dbg_state !== 1'b1 || dbg_k !== 3'd0) begin
          errors++;
          $display("FAIL b2b_chain kept=%0d state=%b k=%0d expected 16 1 0", kept, dbg_state, dbg_k);
        end
      end
    end
    exp_kept = 5'd16;
    tick();
    checks++;
    if ({lb_we_a, lb_we_b, tile_done} !== 3'b000 || kept !== 5'd16 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end we=%b%b done=%b kept=%0d state=%b expected 00 0 16 0",
               lb_we_a, lb_we_b, tile_done, kept, dbg_state);
    end
  endtask

  task automatic test_flush();
    ck_en = 1'b1;
    tile_valid = 1'b1; tile_shrink = 4'hF; tile_x = 9'h040; tile_flip = 1'b0;
    tick();
    tile_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({lb_we_a, lb_we_b} !== 2'b11 || lb_addr_a !== 9'(9'h040 + 2*k)) begin
        errors++;
        $display("FAIL flush_pre step %0d we=%b%b addr=%h expected 11 %h",
                 k, lb_we_a, lb_we_b, lb_addr_a, 9'(9'h040 + 2*k));
      end
    end
    flush = 1'b1;
    tile_valid = 1'b1; tile_x = 9'h080;
    #1;
    checks++;
    if (tile_ready !== 1'b0 || hs_l !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got ready=%b hs_l=%b expected 0 1", tile_ready, hs_l);
    end
    tick();
    flush = 1'b0;
    tile_valid = 1'b0;
    checks++;
    if ({lb_we_a, lb_we_b, tile_done} !== 3'b000 || kept !== exp_kept || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL flush_edge we=%b%b done=%b kept=%0d state=%b expected 00 0 %0d 0",
               lb_we_a, lb_we_b, tile_done, kept, dbg_state, exp_kept);
    end
    test_tile(4'hF, 9'h080, 1'b0);
  endtask

  task automatic test_valid_drop();
    ck_en = 1'b0;
    tile_valid = 1'b1; tile_shrink = 4'hF; tile_x = 9'h010;
    tick();
    tile_valid = 1'b0;
    ck_en = 1'b1;
    tick();
    tick();
    checks++;
    if (dbg_state !== 1'b0 || {lb_we_a, lb_we_b} !== 2'b00) begin
      errors++;
      $display("FAIL valid_drop state=%b we=%b%b expected 0 00", dbg_state, lb_we_a, lb_we_b);
    end
  endtask

  task automatic test_ck_en_quarter();
    logic [27:0] exp_v, got_v;
    logic [8:0]  a;
    ck_en = 1'b0;
    tile_valid = 1'b1; tile_shrink = 4'hF; tile_x = 9'h020; tile_flip = 1'b0;
    tick();
    ck_en = 1'b1;
    tick();
    ck_en = 1'b0;
    tile_valid = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 8; k++) begin
      ck_en = 1'b1;
      tick();
      ck_en = 1'b0;
      a = 9'(9'h020 + 2*k);
      exp_v = {1'b1, 1'b1, a, a + 9'd1, 4'(2*k), 4'(2*k + 1)};
      for (int h = 0; h < 4; h++) begin
        if (h > 0) tick();
        got_v = {lb_we_a, lb_we_b, lb_addr_a, lb_addr_b, lb_pix_a, lb_pix_b};
        checks++;
        if (got_v !== exp_v || tile_done !== ((k == 7 && h == 0) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL quarter step %0d clk %0d got %h done=%b expected %h done=%b",
                   k, h, got_v, tile_done, exp_v, (k == 7 && h == 0));
        end
      end
    end
    exp_kept = 5'd16;
    checks++;
    if (kept !== 5'd16 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL quarter_end kept=%0d state=%b expected 16 0", kept, dbg_state);
    end
    ck_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_tile();
    logic [33:0] all_out;
    ck_en = 1'b1;
    tile_valid = 1'b1; tile_shrink = 4'hF; tile_x = 9'h0A0; tile_flip = 1'b1;
    tick();
    tile_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (lb_we_a !== 1'b1 || lb_addr_a !== 9'h0A2 || lb_pix_a !== 4'd13) begin
      errors++;
      $display("FAIL rst_pre we=%b addr=%h pix=%0d expected 1 0a2 13", lb_we_a, lb_addr_a, lb_pix_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    all_out = {lb_we_a, lb_we_b, lb_addr_a, lb_addr_b, lb_pix_a, lb_pix_b, tile_done, kept};
    checks++;
    if (all_out !== 34'h0 || dbg_state !== 1'b0 || tile_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got %h state=%b ready=%b expected 0 0 1", all_out, dbg_state, tile_ready);
    end
    exp_kept = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({lb_we_a, lb_we_b} !== 2'b00 || dbg_state !== 1'b0 || kept !== 5'd0) begin
      errors++;
      $display("FAIL rst_release we=%b%b state=%b kept=%0d expected 00 0 0",
               lb_we_a, lb_we_b, dbg_state, kept);
    end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tile(4'hF, 9'h020, 1'b0);
    test_tile(4'h0, 9'h100, 1'b0);
    test_tile(4'h0, 9'h100, 1'b1);
    test_tile(4'hF, 9'h1F8, 1'b0);
    test_back_to_back();
    test_tile(4'h7, 9'h050, 1'b1);
    test_flush();
    test_valid_drop();
    test_ck_en_quarter();
    test_reset_mid_tile();
    test_tile(4'h7, 9'h1FC, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
